// File: rtl/ddr_bank_tracker_if.sv
// ddr_bank_tracker_if
//   Groups the DDR4 command pins and the decoded-command / bank-state
//   outputs of ddr_bank_tracker.
//   master : drives cke, cs_n, act_n, A, bg, ba and observes the results.
//   slave  : the tracker. It samples the pins and drives cmd_*, bank_open
//            and err_*.
interface ddr_bank_tracker_if #(
  parameter int RANKS     = 2,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10
);
  localparam int NB = 2**(BGWIDTH+BAWIDTH);
  localparam int RW = (RANKS > 1) ? $clog2(RANKS) : 1;

  logic                         cke;
  logic [RANKS-1:0]             cs_n;
  logic                         act_n;
  logic [ADDRWIDTH-1:0]         A;
  logic [BGWIDTH-1:0]           bg;
  logic [BAWIDTH-1:0]           ba;

  logic [7:0]                   cmd_onehot;
  logic [RW-1:0]                cmd_rank;
  logic [BGWIDTH+BAWIDTH-1:0]   cmd_bank;
  logic [ADDRWIDTH-1:0]         cmd_row;
  logic [COLWIDTH-1:0]          cmd_col;
  logic [RANKS*NB-1:0]          bank_open;
  logic                         err_valid;
  logic [2:0]                   err_code;

  modport master (
    output cke, cs_n, act_n, A, bg, ba,
    input  cmd_onehot, cmd_rank, cmd_bank, cmd_row, cmd_col,
           bank_open, err_valid, err_code
  );
  modport slave (
    input  cke, cs_n, act_n, A, bg, ba,
    output cmd_onehot, cmd_rank, cmd_bank, cmd_row, cmd_col,
           bank_open, err_valid, err_code
  );
endinterface

// File: rtl/ddr_bank_tracker.sv
// ddr_bank_tracker
//   Decodes DDR4 command pins for every rank. Tracks open flag, open row
//   and a timing counter per (rank, bank). A command that violates tRCD,
//   tRP or tRAS, or that does not fit the bank state, is rejected and
//   reported instead of being applied.
//   clk   : sampling clock (rising edge).
//   reset : synchronous, active high.
//   bus   : slave side of ddr_bank_tracker_if. It carries the command pins
//           in and the registered command, bank_open and error outputs.
module ddr_bank_tracker #(
  parameter int RANKS     = 2,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TRAS      = 8
) (
  input logic               clk,
  input logic               reset,
  ddr_bank_tracker_if.slave bus
);
  localparam int BW   = BGWIDTH + BAWIDTH;
  localparam int NB   = 2**BW;
  localparam int NT   = RANKS * NB;
  localparam int IW   = (NT > 1) ? $clog2(NT) : 1;
  localparam int RW   = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int CMAX = (TRCD > TRP) ? ((TRCD > TRAS) ? TRCD : TRAS)
                                     : ((TRP > TRAS) ? TRP : TRAS);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {C_NOP, C_ACT, C_PRE, C_PREA, C_RD, C_RDA,
                            C_WR, C_WRA, C_REF} cmd_e;
  typedef enum logic [2:0] {E_NONE = 3'd0, E_MULTI_CS = 3'd1,
                            E_ACT_OPEN = 3'd2, E_TRP = 3'd3,
                            E_CLOSED = 3'd4, E_TRCD = 3'd5,
                            E_TRAS = 3'd6, E_REF_BUSY = 3'd7} err_e;

  logic [NT-1:0]        r_open;
  logic [ADDRWIDTH-1:0] r_row [NT];
  logic [CW-1:0]        r_cnt [NT];

  logic [7:0]           r_oh;
  logic [RW-1:0]        r_rank;
  logic [BW-1:0]        r_bank;
  logic [ADDRWIDTH-1:0] r_row_o;
  logic [COLWIDTH-1:0]  r_col_o;
  logic                 r_err_v;
  logic [2:0]           r_err_code;

  // Elapsed edge count as seen by the edge now sampling. A bank touched
  // k edges ago reads k here, so the rule "cnt >= T" allows the follow-on
  // command at edge n+T.
  logic [CW-1:0] w_el [NT];
  for (genvar i = 0; i < NT; i++) begin : g_el
    assign w_el[i] = (r_cnt[i] == CW'(CMAX)) ? CW'(CMAX) : r_cnt[i] + CW'(1);
  end

  logic [RW:0]        w_nlow;
  logic [RW-1:0]      w_rank;
  cmd_e               w_cmd;
  logic [BW-1:0]      w_bank;
  logic [IW-1:0]      w_base, w_idx;
  logic [RANKS-1:0]   w_any_open, w_young_open, w_trp_busy;
  err_e               w_err;
  logic               w_take, w_err_v;

  always_comb begin
    w_nlow = '0;
    w_rank = '0;
    for (int r = 0; r < RANKS; r++) begin
      if (!bus.cs_n[r]) begin
        w_nlow = w_nlow + (RW+1)'(1);
        w_rank = RW'(r);
      end
    end

    w_cmd = C_NOP;
    if (!bus.act_n) w_cmd = C_ACT;
    else begin
      case (bus.A[16:14])
        3'b010:  w_cmd = bus.A[10] ? C_PREA : C_PRE;
        3'b101:  w_cmd = bus.A[10] ? C_RDA  : C_RD;
        3'b100:  w_cmd = bus.A[10] ? C_WRA  : C_WR;
        3'b001:  w_cmd = C_REF;
        default: w_cmd = C_NOP;
      endcase
    end

    w_bank = {bus.bg, bus.ba};
    w_base = IW'(w_rank) * IW'(NB);
    w_idx  = w_base + IW'(w_bank);

    // Per-rank summaries that PREA and REF legality need.
    w_any_open   = '0;
    w_young_open = '0;
    w_trp_busy   = '0;
    for (int r = 0; r < RANKS; r++) begin
      for (int b = 0; b < NB; b++) begin
        if (r_open[r*NB+b]) begin
          w_any_open[r] = 1'b1;
          if (w_el[r*NB+b] < CW'(TRAS)) w_young_open[r] = 1'b1;
        end
        if (w_el[r*NB+b] < CW'(TRP)) w_trp_busy[r] = 1'b1;
      end
    end

    w_err = E_NONE;
    if (w_nlow > (RW+1)'(1)) w_err = E_MULTI_CS;
    else begin
      case (w_cmd)
        C_ACT:
          if (r_open[w_idx])                   w_err = E_ACT_OPEN;
          else if (w_el[w_idx] < CW'(TRP))     w_err = E_TRP;
        C_RD, C_RDA, C_WR, C_WRA:
          if (!r_open[w_idx])                  w_err = E_CLOSED;
          else if (w_el[w_idx] < CW'(TRCD))    w_err = E_TRCD;
        C_PRE:
          if (r_open[w_idx] && w_el[w_idx] < CW'(TRAS)) w_err = E_TRAS;
        C_PREA:
          if (w_young_open[w_rank])            w_err = E_TRAS;
        C_REF:
          if (w_any_open[w_rank] || w_trp_busy[w_rank]) w_err = E_REF_BUSY;
        default: w_err = E_NONE;
      endcase
    end

    // A single selected rank with a NOP pattern is silent. Multi-CS is an
    // error whatever the pins decode to.
    w_err_v = bus.cke && ((w_nlow > (RW+1)'(1)) ||
              (w_nlow == (RW+1)'(1) && w_cmd != C_NOP && w_err != E_NONE));
    w_take  = bus.cke && w_nlow == (RW+1)'(1) && w_cmd != C_NOP &&
              w_err == E_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_open     <= '0;
      for (int i = 0; i < NT; i++) begin
        r_row[i] <= '0;
        r_cnt[i] <= CW'(CMAX);
      end
      r_oh       <= '0;
      r_rank     <= '0;
      r_bank     <= '0;
      r_row_o    <= '0;
      r_col_o    <= '0;
      r_err_v    <= 1'b0;
      r_err_code <= '0;
    end else begin
      for (int i = 0; i < NT; i++) r_cnt[i] <= w_el[i];
      r_oh       <= '0;
      r_rank     <= '0;
      r_bank     <= '0;
      r_row_o    <= '0;
      r_col_o    <= '0;
      r_err_v    <= w_err_v;
      r_err_code <= w_err_v ? w_err : E_NONE;
      if (w_take) begin
        r_rank <= w_rank;
        r_bank <= w_bank;
        case (w_cmd)
          C_ACT: begin
            r_oh          <= 8'h80;
            r_row_o       <= bus.A;
            r_open[w_idx] <= 1'b1;
            r_row[w_idx]  <= bus.A;
            r_cnt[w_idx]  <= '0;
          end
          C_PRE: begin
            r_oh <= 8'h40;
            // PRE to a closed bank is reported but leaves its counter alone.
            if (r_open[w_idx]) begin
              r_open[w_idx] <= 1'b0;
              r_cnt[w_idx]  <= '0;
            end
          end
          C_PREA: begin
            r_oh <= 8'h20;
            for (int b = 0; b < NB; b++) begin
              if (r_open[w_base + IW'(b)]) begin
                r_open[w_base + IW'(b)] <= 1'b0;
                r_cnt[w_base + IW'(b)]  <= '0;
              end
            end
          end
          C_RD, C_RDA, C_WR, C_WRA: begin
            case (w_cmd)
              C_RD:    r_oh <= 8'h10;
              C_RDA:   r_oh <= 8'h08;
              C_WR:    r_oh <= 8'h04;
              default: r_oh <= 8'h02;
            endcase
            r_row_o <= r_row[w_idx];
            r_col_o <= bus.A[COLWIDTH-1:0];
            // Auto-precharge closes the bank on the same edge as the access.
            if (w_cmd == C_RDA || w_cmd == C_WRA) begin
              r_open[w_idx] <= 1'b0;
              r_cnt[w_idx]  <= '0;
            end
          end
          C_REF:   r_oh <= 8'h01;
          default: r_oh <= '0;
        endcase
      end
    end
  end

  assign bus.cmd_onehot = r_oh;
  assign bus.cmd_rank   = r_rank;
  assign bus.cmd_bank   = r_bank;
  assign bus.cmd_row    = r_row_o;
  assign bus.cmd_col    = r_col_o;
  assign bus.bank_open  = r_open;
  assign bus.err_valid  = r_err_v;
  assign bus.err_code   = r_err_code;
endmodule

// File: tb/tb_ddr_bank_tracker.sv
module tb_ddr_bank_tracker;
  localparam logic [7:0] OH_ACT = 8'h80, OH_PRE = 8'h40, OH_PREA = 8'h20,
                         OH_RD  = 8'h10, OH_WRA = 8'h02, OH_REF  = 8'h01;
  localparam logic [16:0] A_RD = 17'h14000, A_WRA = 17'h10400,
                          A_PRE = 17'h08000, A_PREA = 17'h08400,
                          A_REF = 17'h04000;

  typedef struct {
    logic [7:0]  oh;
    logic        rank;
    logic [3:0]  bank;
    logic [16:0] row;
    logic [9:0]  col;
    logic        ev;
    logic [2:0]  ec;
    logic [31:0] open;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] eo = '0;
  exp_t sb[$];

  ddr_bank_tracker_if #(.RANKS(2), .BGWIDTH(2), .BAWIDTH(2),
                        .ADDRWIDTH(17), .COLWIDTH(10)) bus ();

  ddr_bank_tracker #(.RANKS(2), .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17),
                     .COLWIDTH(10), .TRCD(4), .TRP(4), .TRAS(8))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Drive one sampled edge, queue what the outputs must show after it,
  // then pop and compare once the edge has passed.
  task automatic cyc(input logic rst, input logic ck, input logic [1:0] csn,
                     input logic actn, input logic [16:0] a,
                     input logic [3:0] bk, input logic [7:0] oh,
                     input logic rk, input logic [16:0] row,
                     input logic [9:0] col, input logic [2:0] ec,
                     input string tag);
    exp_t e;
    reset = rst; bus.cke = ck; bus.cs_n = csn; bus.act_n = actn;
    bus.A = a; {bus.bg, bus.ba} = bk;
    e.oh = oh; e.rank = (oh != 0) ? rk : 1'b0; e.bank = (oh != 0) ? bk : 4'd0;
    e.row = row; e.col = col; e.ev = (ec != 0); e.ec = ec; e.open = eo;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".onehot"}, bus.cmd_onehot, e.oh);
    chk({tag, ".rank"},   bus.cmd_rank,   e.rank);
    chk({tag, ".bank"},   bus.cmd_bank,   e.bank);
    chk({tag, ".row"},    bus.cmd_row,    e.row);
    chk({tag, ".col"},    bus.cmd_col,    e.col);
    chk({tag, ".errv"},   bus.err_valid,  e.ev);
    chk({tag, ".errc"},   bus.err_code,   e.ec);
    chk({tag, ".open"},   bus.bank_open,  e.open);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc(0, 1, 2'b11, 1, 17'h0, 4'd0, 8'h0, 0, 17'h0, 10'h0, 3'd0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ACT held on reset edges is ignored.
    cyc(1, 1, 2'b10, 0, 17'h1ABCD, 4'd6, 8'h0, 0, 17'h0, 10'h0, 3'd0, "rst");
    cyc(1, 1, 2'b10, 0, 17'h1ABCD, 4'd6, 8'h0, 0, 17'h0, 10'h0, 3'd0, "rst");
    // edge n=0: ACT rank0 bg1 ba2
    eo[6] = 1;
    cyc(0, 1, 2'b10, 0, 17'h1ABCD, 4'd6, OH_ACT, 0, 17'h1ABCD, 10'h0, 3'd0, "act0");
    idle(2);
    cyc(0, 1, 2'b10, 1, A_RD | 17'h3F, 4'd6, 8'h0, 0, 17'h0, 10'h0, 3'd5, "rd_trcd");
    cyc(0, 1, 2'b10, 1, A_RD | 17'h3F, 4'd6, OH_RD, 0, 17'h1ABCD, 10'h3F, 3'd0, "rd_ok");
    idle(2);
    cyc(0, 1, 2'b10, 1, A_PRE, 4'd6, 8'h0, 0, 17'h0, 10'h0, 3'd6, "pre_tras");
    eo[6] = 0;
    cyc(0, 1, 2'b10, 1, A_PRE, 4'd6, OH_PRE, 0, 17'h0, 10'h0, 3'd0, "pre_ok");
    idle(2);
    cyc(0, 1, 2'b10, 0, 17'h00123, 4'd6, 8'h0, 0, 17'h0, 10'h0, 3'd3, "act_trp");
    eo[6] = 1;
    cyc(0, 1, 2'b10, 0, 17'h00555, 4'd6, OH_ACT, 0, 17'h00555, 10'h0, 3'd0, "act_ok");
    idle(3);
    eo[6] = 0;
    cyc(0, 1, 2'b10, 1, A_WRA | 17'h10, 4'd6, OH_WRA, 0, 17'h00555, 10'h10, 3'd0, "wra");
    cyc(0, 1, 2'b10, 1, A_RD, 4'd6, 8'h0, 0, 17'h0, 10'h0, 3'd4, "rd_closed");
    cyc(0, 1, 2'b00, 0, 17'h00999, 4'd1, 8'h0, 0, 17'h0, 10'h0, 3'd1, "multi_cs");
    // rank1 bank3 open, REF on rank1 must be refused
    eo[19] = 1;
    cyc(0, 1, 2'b01, 0, 17'h00777, 4'd3, OH_ACT, 1, 17'h00777, 10'h0, 3'd0, "act_r1");
    cyc(0, 1, 2'b01, 1, A_REF, 4'd0, 8'h0, 0, 17'h0, 10'h0, 3'd7, "ref_busy");
    eo[2] = 1;
    cyc(0, 1, 2'b10, 0, 17'h00222, 4'd2, OH_ACT, 0, 17'h00222, 10'h0, 3'd0, "act_r0b2");
    idle(5);
    // 8 edges after act_r1; rank0 bank2 must survive PREA on rank1
    eo[19] = 0;
    cyc(0, 1, 2'b01, 1, A_PREA, 4'd0, OH_PREA, 1, 17'h0, 10'h0, 3'd0, "prea_r1");
    idle(2);
    cyc(0, 1, 2'b01, 1, A_REF, 4'd0, 8'h0, 0, 17'h0, 10'h0, 3'd7, "ref_trp");
    cyc(0, 1, 2'b01, 1, A_REF, 4'd0, OH_REF, 1, 17'h0, 10'h0, 3'd0, "ref_ok");
    cyc(0, 1, 2'b10, 1, A_PRE, 4'd5, OH_PRE, 0, 17'h0, 10'h0, 3'd0, "pre_closed");
    cyc(0, 0, 2'b10, 0, 17'h00333, 4'd7, 8'h0, 0, 17'h0, 10'h0, 3'd0, "cke_low");
    cyc(0, 0, 2'b00, 0, 17'h00333, 4'd7, 8'h0, 0, 17'h0, 10'h0, 3'd0, "cke_low_mcs");
    // reset mid-operation drops all state and ignores the sampled ACT
    eo = '0;
    cyc(1, 1, 2'b10, 0, 17'h00333, 4'd7, 8'h0, 0, 17'h0, 10'h0, 3'd0, "rst_mid");
    eo[2] = 1;
    cyc(0, 1, 2'b10, 0, 17'h1FFFF, 4'd2, OH_ACT, 0, 17'h1FFFF, 10'h0, 3'd0, "act_post_rst");
    idle(1);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
